// File: rtl/popcount_pkg.sv
// Shared types and default sizing for the popcount sequencer.
// GROUPS sets the word width; CW must hold a count of 0..3*GROUPS.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_GROUPS = 4;
    localparam int DEF_CW     = 4;

endpackage

// File: rtl/ones3_counter.sv
// Three-input ones counter (a full adder).
// Output is {carry, sum}, i.e. the number of set inputs.
module ones3_counter (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [1:0] cnt
);

    assign cnt = {(a & b) | (a & c) | (b & c), a ^ b ^ c};

endmodule

// File: rtl/popcount_sequencer.sv
// Serial popcount: one 3-bit group per cycle through a single ones3_counter.
// The accumulated count is published on entry to DONE and held until the next word.
module popcount_sequencer
    import popcount_pkg::*;
#(
    parameter int GROUPS = DEF_GROUPS,
    parameter int CW     = DEF_CW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3*GROUPS-1:0]   data_in,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         count
);

    localparam int W  = 3 * GROUPS;
    localparam int IW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [IW-1:0] LAST = IW'(GROUPS - 1);

    state_t         state;
    state_t         state_nx;
    logic [W-1:0]   sreg;
    logic [CW-1:0]  acc;
    logic [CW-1:0]  acc_sum;
    logic [IW-1:0]  idx;
    logic [1:0]     grp;
    logic           last;

    ones3_counter u_ones (
        .a   (sreg[0]),
        .b   (sreg[1]),
        .c   (sreg[2]),
        .cnt (grp)
    );

    assign acc_sum = acc + CW'(grp);
    assign last    = (idx == LAST);

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            acc   <= '0;
            idx   <= '0;
            count <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sreg <= data_in;
                        acc  <= '0;
                        idx  <= '0;
                    end
                end
                RUN: begin
                    sreg <= sreg >> 3;
                    acc  <= acc_sum;
                    idx  <= last ? '0 : idx + IW'(1);
                    // count must see this cycle's group too
                    if (last) count <= acc_sum;
                end
                default: ;
            endcase
        end
    end

endmodule
